// File: rtl/spi_memory_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_mem_pkg
// Purpose  : Shared definitions for the spiMemory SPI link: frame geometry,
//            R/W bit encoding and the master FSM state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package spi_mem_pkg;

    // One frame is 7 address bits, 1 R/W bit and 8 data bits, MSB first.
    localparam int   FRAME_BITS = 16;
    localparam logic SPI_READ   = 1'b1;
    localparam logic SPI_WRITE  = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } spi_state_t;

endpackage : spi_mem_pkg
`default_nettype wire

// File: rtl/spi_memory_master_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_memory_master_if
// Purpose  : Command/response bundle between a requester and the SPI master.
// Signals  : start, rw, addr, wdata (requester -> master)
//            busy, done, rdata     (master -> requester)
// Modports : master - the requester side
//            slave  - the SPI master side
// Revision : 1.0 - initial release
// ============================================================================
interface spi_memory_master_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);
    logic              start;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rdata;

    modport master (
        output start, rw, addr, wdata,
        input  busy, done, rdata
    );

    modport slave (
        input  start, rw, addr, wdata,
        output busy, done, rdata
    );
endinterface : spi_memory_master_if
`default_nettype wire

// File: rtl/spi_memory_master_sclk_divider.sv
`default_nettype none
// ============================================================================
// Module   : spi_sclk_divider
// Purpose  : SPI clock generator. A half-period counter toggles the sclk flop
//            every CLK_DIV enabled cycles; one-cycle rise/fall ticks flag the
//            clk edge on which sclk is about to change.
// Ports    : clk, rst       - system clock, async active-high reset
//            i_en           - run; when low the counter and sclk are cleared
//            o_sclk         - registered SPI clock, idles low
//            o_rise_tick    - sclk goes high on the coming edge (if enabled)
//            o_fall_tick    - sclk goes low on the coming edge (if enabled)
// Revision : 1.0 - initial release
// ============================================================================
module spi_sclk_divider #(
    parameter int CLK_DIV = 3   // legal range 2..255
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_en,
    output logic      o_sclk,
    output logic      o_rise_tick,
    output logic      o_fall_tick
);

    localparam logic [7:0] c_CNT_LAST = 8'(CLK_DIV - 1);

    logic [7:0] r_cnt;
    logic       r_sclk;
    logic       w_tc;

    assign w_tc = (r_cnt == c_CNT_LAST);

    // The ticks are decoded from count and sclk only, not from i_en, so the
    // caller can use a tick to decide to drop i_en on that very edge and
    // keep sclk parked low instead of toggling it.
    assign o_rise_tick = w_tc & ~r_sclk;
    assign o_fall_tick = w_tc &  r_sclk;
    assign o_sclk      = r_sclk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= 8'd0;
            r_sclk <= 1'b0;
        end else if (!i_en) begin
            r_cnt  <= 8'd0;
            r_sclk <= 1'b0;
        end else if (w_tc) begin
            r_cnt  <= 8'd0;
            r_sclk <= ~r_sclk;
        end else begin
            r_cnt  <= r_cnt + 8'd1;
        end
    end

endmodule : spi_sclk_divider
`default_nettype wire

// File: rtl/spi_memory_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_memory_master
// Purpose  : SPI mode-0 master for the spiMemory slave. Turns a one-cycle
//            command into a 16-bit frame {addr, rw, data} sent MSB first and
//            captures the read byte returned on the last 8 sclk rises.
// Ports    : clk, reset     - system clock, async active-high reset
//            cmd (slave)    - start/rw/addr/wdata in, busy/done/rdata out
//            sclk_pin       - SPI clock, idles low
//            cs_pin         - chip select, active low
//            mosi_pin       - master-out serial data
//            miso_pin       - slave-out serial data
// Revision : 1.0 - initial release
// ============================================================================
module spi_memory_master
    import spi_mem_pkg::*;
#(
    parameter int CLK_DIV = 3,   // clk cycles per sclk half-period, 2..255
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8
) (
    input  wire logic              clk,
    input  wire logic              reset,
    spi_memory_master_if.slave     cmd,
    output logic                   sclk_pin,
    output logic                   cs_pin,
    output logic                   mosi_pin,
    input  wire logic              miso_pin
);

    localparam int         c_FRAME_W   = ADDR_W + 1 + DATA_W;
    localparam logic [3:0] c_LAST_BIT  = 4'(FRAME_BITS - 1);
    localparam logic [7:0] c_HOLD_LAST = 8'(CLK_DIV - 1);

    spi_state_t            r_state;
    logic [c_FRAME_W-1:0]  r_tx;
    logic [DATA_W-1:0]     r_rx;
    logic [3:0]            r_bit_cnt;
    logic                  r_tx_done;
    logic                  r_is_read;
    logic [7:0]            r_hold_cnt;
    logic                  r_cs;
    logic                  r_busy;
    logic                  r_done;
    logic [DATA_W-1:0]     r_rdata;

    logic                  w_div_en;
    logic                  w_rise_tick;
    logic                  w_fall_tick;
    logic                  w_sclk;
    logic [DATA_W-1:0]     w_load_data;

    // Reads send zeros in the data field.
    assign w_load_data = (cmd.rw == SPI_WRITE) ? cmd.wdata : {DATA_W{1'b0}};

    // After the 16th fall the divider keeps running for one more low
    // half-period; the tick that would be a 17th rise instead ends SHIFT,
    // and enable is dropped on that same edge so sclk never pulses.
    assign w_div_en = (r_state == ST_SETUP) ||
                      ((r_state == ST_SHIFT) && !(r_tx_done && w_rise_tick));

    spi_sclk_divider #(
        .CLK_DIV     (CLK_DIV)
    ) u_sclk_div (
        .clk         (clk),
        .rst         (reset),
        .i_en        (w_div_en),
        .o_sclk      (w_sclk),
        .o_rise_tick (w_rise_tick),
        .o_fall_tick (w_fall_tick)
    );

    assign sclk_pin  = w_sclk;
    assign cs_pin    = r_cs;
    assign mosi_pin  = r_tx[c_FRAME_W-1];
    assign cmd.busy  = r_busy;
    assign cmd.done  = r_done;
    assign cmd.rdata = r_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_tx       <= '0;
            r_rx       <= '0;
            r_bit_cnt  <= 4'd0;
            r_tx_done  <= 1'b0;
            r_is_read  <= 1'b0;
            r_hold_cnt <= 8'd0;
            r_cs       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd.start) begin
                        r_tx      <= {cmd.addr, cmd.rw, w_load_data};
                        r_is_read <= (cmd.rw == SPI_READ);
                        r_bit_cnt <= 4'd0;
                        r_tx_done <= 1'b0;
                        r_cs      <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    // First rise: sample miso, bit 15 is already on mosi.
                    if (w_rise_tick) begin
                        r_rx    <= {r_rx[DATA_W-2:0], miso_pin};
                        r_state <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (w_rise_tick) begin
                        if (r_tx_done) begin
                            r_hold_cnt <= 8'd0;
                            r_state    <= ST_HOLD;
                        end else begin
                            r_rx <= {r_rx[DATA_W-2:0], miso_pin};
                        end
                    end
                    if (w_fall_tick) begin
                        // The last fall leaves bit 0 on mosi instead of shifting.
                        if (r_bit_cnt == c_LAST_BIT) begin
                            r_tx_done <= 1'b1;
                        end else begin
                            r_tx      <= {r_tx[c_FRAME_W-2:0], 1'b0};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                end

                ST_HOLD: begin
                    if (r_hold_cnt == c_HOLD_LAST) begin
                        r_cs    <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                        // Sixteen rises leave exactly rises 9..16 in r_rx.
                        if (r_is_read) begin
                            r_rdata <= r_rx;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule : spi_memory_master
`default_nettype wire

// File: tb/tb_spi_memory_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_memory_master
// Purpose  : Self-checking bench for spi_memory_master with a behavioural
//            spiMemory slave, a reference memory model and a done-driven
//            scoreboard.
// Ports    : none (top-level bench)
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_memory_master
    import spi_mem_pkg::*;
;
    localparam int CLK_DIV       = 3;
    localparam int CS_LOW_CYCLES = 34 * CLK_DIV;

    logic clk      = 1'b0;
    logic reset    = 1'b1;
    logic miso_pin = 1'b0;
    logic sclk_pin;
    logic cs_pin;
    logic mosi_pin;

    spi_memory_master_if #(.ADDR_W(7), .DATA_W(8)) cmd_if ();

    spi_memory_master #(
        .CLK_DIV  (CLK_DIV),
        .ADDR_W   (7),
        .DATA_W   (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd      (cmd_if),
        .sclk_pin (sclk_pin),
        .cs_pin   (cs_pin),
        .mosi_pin (mosi_pin),
        .miso_pin (miso_pin)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // ---------------- behavioural spiMemory slave (the device) -------------
    logic [7:0]  slv_mem [128];
    logic [15:0] slv_frame      = '0;
    logic [15:0] slv_last_frame = '0;
    logic [7:0]  slv_out        = '0;
    logic        slv_rd         = 1'b0;
    int          slv_bits       = 0;

    always @(negedge cs_pin) begin
        slv_bits  = 0;
        slv_frame = '0;
        slv_rd    = 1'b0;
        miso_pin  = 1'($urandom);
    end

    always @(posedge sclk_pin) begin
        if (cs_pin == 1'b0) begin
            slv_frame = {slv_frame[14:0], mosi_pin};
            slv_bits++;
        end
    end

    // Mode 0: drive new miso data after each fall; junk before the data phase.
    always @(negedge sclk_pin) begin
        if (cs_pin == 1'b0) begin
            if (slv_bits == 8) begin
                slv_rd  = (slv_frame[0] == SPI_READ);
                slv_out = slv_mem[slv_frame[7:1]];
            end
            if (slv_rd && slv_bits >= 8 && slv_bits < 16)
                miso_pin = slv_out[3'(15 - slv_bits)];
            else
                miso_pin = 1'($urandom);
        end
    end

    always @(posedge cs_pin) begin
        if (slv_bits == 16) begin
            slv_last_frame = slv_frame;
            if (slv_frame[8] == SPI_WRITE)
                slv_mem[slv_frame[15:9]] = slv_frame[7:0];
        end
    end

    // ---------------- reference model and scoreboard -----------------------
    typedef struct {
        logic [15:0] frame;
        logic [7:0]  rdata;
    } exp_t;

    exp_t       exp_q [$];
    logic [7:0] ref_mem [128];
    logic [7:0] ref_rdata = 8'h00;

    task automatic predict(input logic rw_i, input logic [6:0] a, input logic [7:0] d);
        exp_t e;
        e.frame = {a, rw_i, (rw_i == SPI_READ) ? 8'h00 : d};
        if (rw_i == SPI_READ) ref_rdata = ref_mem[a];
        else                  ref_mem[a] = d;
        e.rdata = ref_rdata;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic rw_i, input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        cmd_if.rw    = rw_i;
        cmd_if.addr  = a;
        cmd_if.wdata = d;
        cmd_if.start = 1'b1;
        @(negedge clk);
        cmd_if.start = 1'b0;
        // Scramble the command inputs; the frame must not follow them.
        cmd_if.rw    = 1'($urandom);
        cmd_if.addr  = 7'($urandom);
        cmd_if.wdata = 8'($urandom);
    endtask

    task automatic issue(input logic rw_i, input logic [6:0] a, input logic [7:0] d);
        predict(rw_i, a, d);
        drive(rw_i, a, d);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (cmd_if.busy && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (cmd_if.busy) fail_now("idle_timeout");
    endtask

    // ---------------- monitor ----------------------------------------------
    int   mon_cs_low = 0;
    int   mon_rises  = 0;
    logic prev_cs    = 1'b1;
    logic prev_sclk  = 1'b0;
    logic prev_done  = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            mon_cs_low = 0;
            mon_rises  = 0;
        end else begin
            if (!cs_pin) begin
                if (prev_cs) begin
                    mon_cs_low = 0;
                    mon_rises  = 0;
                end
                mon_cs_low++;
            end
            if (sclk_pin && !prev_sclk) mon_rises++;
            if (cmd_if.done) begin
                check("done_one_cycle", 32'(prev_done), 32'd0);
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("mosi_frame", 32'(slv_last_frame), 32'(e.frame));
                    check("rdata", 32'(cmd_if.rdata), 32'(e.rdata));
                    check("sclk_rises", 32'(mon_rises), 32'd16);
                    check("cs_low_cycles", 32'(mon_cs_low), 32'(CS_LOW_CYCLES));
                    check("cs_high_at_done", 32'(cs_pin), 32'd1);
                    check("busy_low_at_done", 32'(cmd_if.busy), 32'd0);
                end
            end
        end
        prev_cs   = cs_pin;
        prev_sclk = sclk_pin;
        prev_done = cmd_if.done;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ---------------------------------------------
    initial begin
        cmd_if.start = 1'b0;
        cmd_if.rw    = 1'b0;
        cmd_if.addr  = '0;
        cmd_if.wdata = '0;
        for (int i = 0; i < 128; i++) begin
            logic [7:0] v;
            v          = 8'($urandom);
            slv_mem[i] = v;
            ref_mem[i] = v;
        end

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_cs", 32'(cs_pin), 32'd1);
        check("reset_sclk", 32'(sclk_pin), 32'd0);
        check("reset_mosi", 32'(mosi_pin), 32'd0);
        check("reset_busy", 32'(cmd_if.busy), 32'd0);
        check("reset_done", 32'(cmd_if.done), 32'd0);
        check("reset_rdata", 32'(cmd_if.rdata), 32'd0);
        reset = 1'b0;

        // Write 0x55 to 0x2A.
        issue(SPI_WRITE, 7'h2A, 8'h55);
        wait_idle();

        // Slave holds 0xA5 at 0x2A; read it with non-zero wdata on the bus.
        slv_mem[7'h2A] = 8'hA5;
        ref_mem[7'h2A] = 8'hA5;
        issue(SPI_READ, 7'h2A, 8'hFF);
        wait_idle();

        // Write then read back through the slave memory.
        issue(SPI_WRITE, 7'h05, 8'h3C);
        wait_idle();
        issue(SPI_READ, 7'h05, 8'h00);
        wait_idle();

        // Starts while busy are ignored.
        issue(SPI_READ, 7'h05, 8'h00);
        repeat (9) @(negedge clk);
        cmd_if.rw = SPI_WRITE; cmd_if.addr = 7'h11; cmd_if.wdata = 8'hEE; cmd_if.start = 1'b1;
        @(negedge clk);
        cmd_if.start = 1'b0;
        repeat (39) @(negedge clk);
        cmd_if.rw = SPI_WRITE; cmd_if.addr = 7'h12; cmd_if.wdata = 8'hDD; cmd_if.start = 1'b1;
        @(negedge clk);
        cmd_if.start = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);
        check("ignored_start_not_queued", 32'(cmd_if.busy), 32'd0);

        // Start held through done: back-to-back frames with a 1-cycle cs gap.
        begin
            int k = 0;
            predict(SPI_WRITE, 7'h33, 8'h96);
            @(negedge clk);
            cmd_if.rw = SPI_WRITE; cmd_if.addr = 7'h33; cmd_if.wdata = 8'h96; cmd_if.start = 1'b1;
            @(negedge clk);
            predict(SPI_READ, 7'h33, 8'h5A);
            cmd_if.rw = SPI_READ; cmd_if.wdata = 8'h5A;
            while (!cmd_if.done && k < 1000) begin
                @(negedge clk);
                k++;
            end
            if (!cmd_if.done) fail_now("b2b_done_timeout");
            check("b2b_cs_high_in_done", 32'(cs_pin), 32'd1);
            @(negedge clk);
            check("b2b_cs_low_next", 32'(cs_pin), 32'd0);
            check("b2b_busy_next", 32'(cmd_if.busy), 32'd1);
            cmd_if.start = 1'b0;
            wait_idle();
        end

        // Reset after the 5th rise of a read: frame aborted, no done.
        begin
            int k = 0;
            drive(SPI_READ, 7'h2A, 8'h00);
            while (slv_bits < 5 && k < 1000) begin
                @(negedge clk);
                k++;
            end
            if (slv_bits < 5) fail_now("rise5_timeout");
            #2 reset = 1'b1;
            #1;
            check("rst_mid_cs", 32'(cs_pin), 32'd1);
            check("rst_mid_sclk", 32'(sclk_pin), 32'd0);
            check("rst_mid_busy", 32'(cmd_if.busy), 32'd0);
            check("rst_mid_rdata", 32'(cmd_if.rdata), 32'd0);
            check("rst_mid_done", 32'(cmd_if.done), 32'd0);
            ref_rdata = 8'h00;
            @(negedge clk);
            @(negedge clk);
            reset = 1'b0;
            issue(SPI_READ, 7'h2A, 8'h00);
            wait_idle();
        end

        // Randomised traffic over a small address window so reads hit writes.
        for (int i = 0; i < 14; i++) begin
            logic       r;
            logic [6:0] a;
            logic [7:0] d;
            r = 1'($urandom);
            a = 7'($urandom_range(0, 7));
            d = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(r, a, d);
            wait_idle();
        end

        repeat (50) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_spi_memory_master
`default_nettype wire
